// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with registered, held grants.
// The scan starts at a rotating pointer so the last winner becomes lowest
// priority. Optional hold timeout is enabled by defining ARB_TIMEOUT_EN; in the
// default build the owner keeps the grant until it drops its request.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic [1:0] gnt_pos
);

    // Reject illegal hold limits when the design is elaborated.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter4: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_reg;
    logic [1:0] ptr_reg;
    logic [3:0] gnt_reg;
    logic [1:0] pos_reg;

    logic [3:0] cand;
    logic [3:0] rot;
    logic [1:0] offset;
    logic [1:0] winner;
    logic       have_cand;
    logic       owner_req;
    logic       force_handoff;
    logic       take_new;
    logic       go_idle;

    // Candidates for the scan: every request, minus the current owner while granted.
    always_comb begin
        cand = req;
        if (state_reg == GRANT) begin
            cand[pos_reg] = 1'b0;
        end
    end

    // Rotate candidates so that bit 0 corresponds to the pointer position.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot[gi] = cand[2'(ptr_reg + 2'(gi))];
    end

    // First-set-bit encoder on the rotated vector.
    always_comb begin
        casez (rot)
            4'b???1: offset = 2'd0;
            4'b??10: offset = 2'd1;
            4'b?100: offset = 2'd2;
            4'b1000: offset = 2'd3;
            default: offset = 2'd0;
        endcase
    end

    assign winner    = 2'(ptr_reg + offset);
    assign have_cand = |cand;
    assign owner_req = req[pos_reg];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] cnt_reg;

    // Consecutive-hold counter: cleared on every new grant, saturates at the limit.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_reg <= 8'd0;
        end else if (take_new) begin
            cnt_reg <= 8'd0;
        end else if (state_reg == GRANT && cnt_reg != HOLD_LAST) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    assign force_handoff = (state_reg == GRANT) && (cnt_reg == HOLD_LAST) && have_cand;
`else
    assign force_handoff = 1'b0;
`endif

    // Arbitration decision for the coming edge.
    assign take_new = (state_reg == IDLE) ? have_cand
                                          : ((!owner_req || force_handoff) && have_cand);
    assign go_idle  = (state_reg == GRANT) && !owner_req && !have_cand;

    // Arbiter FSM with registered grant, owner index and rotating pointer.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_reg <= IDLE;
            ptr_reg   <= 2'd0;
            gnt_reg   <= 4'b0000;
            pos_reg   <= 2'd0;
        end else if (take_new) begin
            state_reg <= GRANT;
            gnt_reg   <= 4'b0001 << winner;
            pos_reg   <= winner;
            ptr_reg   <= 2'(winner + 2'd1);
        end else if (go_idle) begin
            state_reg <= IDLE;
            gnt_reg   <= 4'b0000;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_valid = |gnt_reg;
    assign gnt_pos   = pos_reg;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed scenarios plus randomized requests, each cycle
// compared with a behavioural round-robin model (owner index, pointer and
// number of cycles held). Build with ARB_TIMEOUT_EN to cover the hold timeout.
module tb_rr_arbiter4;

    localparam int TB_MAX_HOLD = 4;

    logic       clk;
    logic       areset_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_pos;

    int n_compared;
    int n_mismatched;
    int cyc;

    // Reference model state
    int m_owner;   // -1 when nobody owns the resource
    int m_ptr;     // index scanned first
    int m_last;    // last owner index
    int m_held;    // cycles the current owner has held the grant

    rr_arbiter4 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .gnt_pos  (gnt_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_last  = 0;
        m_held  = 0;
    endfunction

    // Round-robin pick: first requester at or after the pointer, skipping excl.
    function automatic int model_pick(input logic [3:0] r, input int excl);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    function automatic void model_grant(input int w);
        m_owner = w;
        m_last  = w;
        m_ptr   = (w + 1) % 4;
        m_held  = 1;
    endfunction

    function automatic void model_step(input logic [3:0] r);
        int  w;
        bit  contended;
        bit  forced;
        if (m_owner < 0) begin
            w = model_pick(r, -1);
            if (w >= 0) model_grant(w);
        end else begin
            contended = (r & ~(4'b0001 << m_owner)) != 4'b0000;
            forced    = 1'b0;
`ifdef ARB_TIMEOUT_EN
            forced = (m_held >= TB_MAX_HOLD) && contended;
`endif
            if (r[m_owner] && !forced) begin
                if (m_held < 1000) m_held++;
            end else begin
                w = model_pick(r, m_owner);
                if (w >= 0) model_grant(w);
                else m_owner = -1;
            end
        end
    endfunction

    task automatic check_outputs();
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check_eq("gnt", 32'(gnt), 32'(exp_gnt));
        check_eq("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check_eq("gnt_pos", 32'(gnt_pos), 32'(m_last));
        check_eq("onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    // One transaction: drive req away from the edge, let the DUT and model step, compare.
    task automatic cycle(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        cyc++;
        $display("cyc %0d req=%b gnt=%b valid=%b pos=%0d", cyc, r, gnt, gnt_valid, gnt_pos);
        check_outputs();
    endtask

    // Pulse reset between edges and check the outputs clear without a clock edge.
    task automatic async_reset_pulse();
        @(negedge clk);
        #1 areset_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_valid", 32'(gnt_valid), 32'd0);
        check_eq("rst_pos", 32'(gnt_pos), 32'd0);
        #1 areset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        n_compared   = 0;
        n_mismatched = 0;
        cyc          = 0;
        req          = 4'b0000;
        areset_n     = 1'b0;
        model_reset();

        #2;
        check_eq("reset_gnt", 32'(gnt), 32'd0);
        check_eq("reset_valid", 32'(gnt_valid), 32'd0);
        check_eq("reset_pos", 32'(gnt_pos), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset_n = 1'b1;

        // All four requesting; each owner drops in turn -> order 0,1,2,3
        cycle(4'b1111);
        check_eq("t1_first_gnt", 32'(gnt), 32'h1);
        cycle(4'b1111);
        cycle(4'b1111);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b1111 & ~(4'b0001 << k));
            check_eq("t1_order", 32'(gnt_pos), 32'((k + 1) % 4));
            cycle(4'b1111);
        end

        // Pointer wrap: owner 2 releases with 3 and 0 waiting
        model_reset();
        async_reset_pulse();
        cycle(4'b0100);
        cycle(4'b1001);
        check_eq("t2_wrap_to3", 32'(gnt), 32'h8);
        cycle(4'b0001);
        check_eq("t2_wrap_to0", 32'(gnt), 32'h1);
        cycle(4'b0000);

        // Idle path: single requester then release, position retained
        repeat (3) cycle(4'b0100);
        check_eq("t3_held", 32'(gnt), 32'h4);
        cycle(4'b0000);
        check_eq("t3_idle_gnt", 32'(gnt), 32'h0);
        check_eq("t3_idle_pos", 32'(gnt_pos), 32'd2);

        // Async reset mid-grant, then restart from pointer 0
        cycle(4'b0010);
        async_reset_pulse();
        cycle(4'b0110);
        check_eq("t4_after_rst", 32'(gnt), 32'h2);
        cycle(4'b0000);

        // Two-way contention held constant
        repeat (20) cycle(4'b0011);
        cycle(4'b0000);

        // Uncontended long hold
        repeat (20) begin
            cycle(4'b1000);
            check_eq("t6_hold", 32'(gnt), 32'h8);
        end
        cycle(4'b0000);

        // Randomized, mostly-stable requests with occasional async resets
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = r ^ 4'($urandom);
            if ($urandom_range(0, 149) == 0) async_reset_pulse();
            cycle(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
